// File: rtl/dm163_pkg.sv
// Shared geometry, FSM encodings and channel-decode helpers for the DM163 receive monitor.
package dm163_pkg;

  localparam int unsigned PIXELS_PER_COL = 8;
  localparam int unsigned BITS_PER_PIXEL = 24;
  localparam int unsigned N_BITS         = PIXELS_PER_COL * BITS_PER_PIXEL;
  localparam int unsigned N_COLS         = 8;
  localparam int unsigned CNT_W          = 8;
  localparam int unsigned COL_W          = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [N_COLS-1:0] v);
    return (v != '0) && ((v & (v - N_COLS'(1))) == '0);
  endfunction

  // Position of the lowest set bit; only meaningful for one-hot input.
  function automatic logic [COL_W-1:0] onehot_index(input logic [N_COLS-1:0] v);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = N_COLS - 1; i >= 0; i--) begin
      if (v[i]) idx = COL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on an already-registered level; keeps the previous value.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise_c = d & ~prev;

endmodule

// File: rtl/dm163_rx_monitor.sv
// Captures DM163 serial frames into a per-column pixel store and flags length/channel errors.
module dm163_rx_monitor
  import dm163_pkg::*;
#(
  parameter int unsigned PIXELS_PER_COL = dm163_pkg::PIXELS_PER_COL,
  parameter int unsigned BITS_PER_PIXEL = dm163_pkg::BITS_PER_PIXEL
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_sda,
  input  logic                      s_clk,
  input  logic                      latch,
  input  logic [7:0]                channel,
  input  logic [5:0]                rd_addr,
  output logic [BITS_PER_PIXEL-1:0] rd_data,
  output logic [7:0]                col_valid,
  output logic                      frame_done,
  output logic                      err_len,
  output logic                      err_chan
);

  localparam int unsigned FRAME_BITS = PIXELS_PER_COL * BITS_PER_PIXEL;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   sda_q;
  logic                   sclk_q;
  logic                   latch_q;
  logic [N_COLS-1:0]      chan_q;
  logic                   sclk_rise_c;
  logic                   latch_rise_c;
  logic                   chan_rise_c;

  logic [FRAME_BITS-1:0]  shift;
  logic [FRAME_BITS-1:0]  shift_next_c;
  logic [FRAME_BITS-1:0]  hold;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next_c;
  logic [FRAME_BITS-1:0]  mem [N_COLS];

  logic [0:0]             state;
  logic [0:0]             state_next_c;
  logic                   wr_en_c;
  logic                   chan_err_c;
  logic [COL_W-1:0]       wr_col_c;

  // Input sampling; s_sda travels with s_clk so the shifted bit lines up with its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_q   <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      chan_q  <= '0;
    end else begin
      sda_q   <= s_sda;
      sclk_q  <= s_clk;
      latch_q <= latch;
      chan_q  <= channel;
    end
  end

  edge_detect u_sclk_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (sclk_q),
    .rise_c (sclk_rise_c)
  );

  edge_detect u_latch_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (latch_q),
    .rise_c (latch_rise_c)
  );

  edge_detect u_chan_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (|chan_q),
    .rise_c (chan_rise_c)
  );

  // Shift and count first so a coincident latch edge captures the bit arriving with it.
  always_comb begin
    shift_next_c = shift;
    cnt_next_c   = cnt;
    if (sclk_rise_c) begin
      shift_next_c = {shift[FRAME_BITS-2:0], sda_q};
      if (cnt != CNT_MAX) cnt_next_c = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      hold    <= '0;
      cnt     <= '0;
      err_len <= 1'b0;
    end else begin
      shift <= shift_next_c;
      if (latch_rise_c) begin
        hold <= shift_next_c;
        cnt  <= '0;
        if (cnt_next_c != CNT_W'(FRAME_BITS)) err_len <= 1'b1;
      end else begin
        cnt <= cnt_next_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next_c;
  end

  // A latch edge arms the column write; the next channel select commits or rejects it.
  always_comb begin
    state_next_c = state;
    wr_en_c      = 1'b0;
    chan_err_c   = 1'b0;
    wr_col_c     = onehot_index(chan_q);
    case (state)
      ST_IDLE: begin
        if (latch_rise_c) state_next_c = ST_HELD;
      end
      ST_HELD: begin
        if (latch_rise_c) begin
          state_next_c = ST_HELD;
        end else if (chan_rise_c) begin
          state_next_c = ST_IDLE;
          if (is_onehot(chan_q)) wr_en_c    = 1'b1;
          else                   chan_err_c = 1'b1;
        end
      end
      default: state_next_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_COLS); i++) mem[i] <= '0;
      col_valid  <= '0;
      frame_done <= 1'b0;
      err_chan   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (chan_err_c) err_chan <= 1'b1;
      if (wr_en_c) begin
        mem[wr_col_c] <= hold;
        if (wr_col_c == COL_W'(N_COLS - 1)) begin
          col_valid  <= '0;
          frame_done <= 1'b1;
        end else begin
          col_valid <= col_valid | (N_COLS'(1) << wr_col_c);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr[5:3]][BITS_PER_PIXEL*32'(rd_addr[2:0]) +: BITS_PER_PIXEL];
  end

endmodule

// File: tb/tb_dm163_rx_monitor.sv
// Randomized bench for dm163_rx_monitor against a frame-level behavioural model.
module tb_dm163_rx_monitor;

  localparam int NB  = 192;
  localparam int BPP = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_sda = 1'b0;
  logic           s_clk = 1'b0;
  logic           latch = 1'b0;
  logic [7:0]     channel = 8'h00;
  logic [5:0]     rd_addr = 6'o00;
  logic [BPP-1:0] rd_data;
  logic [7:0]     col_valid;
  logic           frame_done;
  logic           err_len;
  logic           err_chan;

  dm163_rx_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_sda      (s_sda),
    .s_clk      (s_clk),
    .latch      (latch),
    .channel    (channel),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .col_valid  (col_valid),
    .frame_done (frame_done),
    .err_len    (err_len),
    .err_chan   (err_chan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fd_seen = 0;

  always @(negedge clk) if (rst_n && frame_done) fd_seen++;

  // Behavioural model: whole frames, pixel arrays and flags.
  logic [NB-1:0] m_shift;
  logic [NB-1:0] m_hold;
  logic [NB-1:0] m_col [8];
  logic [7:0]    m_valid;
  int            m_cnt;
  bit            m_held;
  bit            m_err_len;
  bit            m_err_chan;
  int            m_fd;

  function automatic logic [NB-1:0] pix_vec(input logic [BPP-1:0] p [8]);
    logic [NB-1:0] v;
    for (int r = 0; r < 8; r++) v[BPP*r +: BPP] = p[r];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_sda = 0; s_clk = 0; latch = 0; channel = 0; rd_addr = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    m_shift = '0; m_hold = '0; m_valid = 0; m_cnt = 0; m_held = 0;
    m_err_len = 0; m_err_chan = 0; m_fd = 0; fd_seen = 0;
    for (int c = 0; c < 8; c++) m_col[c] = '0;
  endtask

  task automatic model_bit(input logic b);
    m_shift = {m_shift[NB-2:0], b};
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_latch();
    m_hold = m_shift;
    if (m_cnt != NB) m_err_len = 1;
    m_cnt  = 0;
    m_held = 1;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    s_sda = b; s_clk = 1'b1;
    @(negedge clk);
    s_clk = 1'b0;
    model_bit(b);
  endtask

  task automatic send_bits(input logic [NB-1:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_latch();
    @(negedge clk);
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(1);
    model_latch();
  endtask

  task automatic do_select(input logic [7:0] ch);
    int c;
    @(negedge clk);
    channel = ch;
    tick(2);
    channel = 8'h00;
    tick(3);
    if (m_held) begin
      if ($countones(ch) == 1) begin
        c = 0;
        for (int i = 0; i < 8; i++) if (ch[i]) c = i;
        m_col[c] = m_hold;
        if (c == 7) begin m_valid = 0; m_fd++; end
        else m_valid[c] = 1'b1;
      end else begin
        m_err_chan = 1;
      end
      m_held = 0;
    end
  endtask

  task automatic send_column(input logic [BPP-1:0] p [8], input int col);
    send_bits(pix_vec(p), NB);
    do_latch();
    do_select(8'(1 << col));
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_data !== '0) $display("FAIL reset_rd_data got %h want 0", rd_data); else passes++;
    checks++; if (col_valid !== 8'h00) $display("FAIL reset_col_valid got %h want 00", col_valid); else passes++;
    checks++; if ({frame_done, err_len, err_chan} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {frame_done, err_len, err_chan}); else passes++;
  endtask

  task automatic test_single_column();
    logic [BPP-1:0] p [8];
    logic [BPP-1:0] exp;
    for (int r = 0; r < 8; r++) p[r] = 24'hFF0000;
    send_column(p, 0);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); rd_addr = 6'(r);
      @(negedge clk);
      exp = m_col[0][BPP*r +: BPP];
      checks++; if (rd_data !== 24'hFF0000 || rd_data !== exp)
        $display("FAIL single_col_row%0d got %h want FF0000", r, rd_data); else passes++;
    end
    checks++; if (col_valid !== 8'h01) $display("FAIL single_col_valid got %h want 01", col_valid); else passes++;
    checks++; if ({err_len, err_chan} !== 2'b00)
      $display("FAIL single_col_errs got %b want 00", {err_len, err_chan}); else passes++;
  endtask

  task automatic test_full_frame();
    logic [BPP-1:0] p [8];
    int fd0;
    bit ok;
    do_reset();
    fd0 = fd_seen;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) p[r] = 24'h0000C0 + 24'(c);
      send_column(p, c);
      if (c == 6) begin
        checks++; if (col_valid !== 8'h7F) $display("FAIL frame_valid_c6 got %h want 7f", col_valid); else passes++;
      end
    end
    checks++; if (fd_seen - fd0 !== m_fd) $display("FAIL frame_done_pulses got %0d want %0d", fd_seen - fd0, m_fd); else passes++;
    checks++; if (col_valid !== m_valid) $display("FAIL frame_valid_cleared got %h want %h", col_valid, m_valid); else passes++;
    ok = 1;
    for (int a = 0; a < 64; a++) begin
      @(negedge clk); rd_addr = 6'(a);
      @(negedge clk);
      if (rd_data !== (24'h0000C0 + 24'(a / 8)) || rd_data !== m_col[a/8][BPP*(a%8) +: BPP]) begin
        $display("FAIL frame_read addr %o got %h want %h", a, rd_data, 24'h0000C0 + 24'(a / 8));
        ok = 0;
      end
    end
    checks++; if (ok) passes++;
  endtask

  task automatic test_short_frame();
    logic [NB-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(v, NB - 1);
    do_latch();
    checks++; if (err_len !== 1'b1) $display("FAIL short_err_len got %b want 1", err_len); else passes++;
    do_select(8'h04);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); rd_addr = {3'd2, 3'(r)};
      @(negedge clk);
      checks++; if (rd_data !== m_col[2][BPP*r +: BPP])
        $display("FAIL short_data_row%0d got %h want %h", r, rd_data, m_col[2][BPP*r +: BPP]); else passes++;
    end
    checks++; if (col_valid !== m_valid) $display("FAIL short_valid got %h want %h", col_valid, m_valid); else passes++;
  endtask

  task automatic test_bad_channel();
    logic [NB-1:0] v;
    logic [7:0] valid0;
    valid0 = col_valid;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(v, NB);
    do_latch();
    do_select(8'h03);
    checks++; if (err_chan !== 1'b1) $display("FAIL badch_err_chan got %b want 1", err_chan); else passes++;
    checks++; if (col_valid !== valid0 || col_valid !== m_valid)
      $display("FAIL badch_valid got %h want %h", col_valid, m_valid); else passes++;
    // Back in IDLE: a later select must not write column 0.
    do_select(8'h01);
    @(negedge clk); rd_addr = 6'o03;
    @(negedge clk);
    checks++; if (rd_data !== m_col[0][BPP*3 +: BPP])
      $display("FAIL badch_idle_write got %h want %h", rd_data, m_col[0][BPP*3 +: BPP]); else passes++;
    checks++; if (col_valid !== m_valid) $display("FAIL badch_idle_valid got %h want %h", col_valid, m_valid); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [NB-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(v, 100);
    do_reset();
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(v, NB);
    do_latch();
    do_select(8'h20);
    checks++; if (err_len !== 1'b0) $display("FAIL midrst_err_len got %b want 0", err_len); else passes++;
    checks++; if (col_valid !== 8'h20) $display("FAIL midrst_valid got %h want 20", col_valid); else passes++;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); rd_addr = {3'd5, 3'(r)};
      @(negedge clk);
      checks++; if (rd_data !== v[BPP*r +: BPP])
        $display("FAIL midrst_row%0d got %h want %h", r, rd_data, v[BPP*r +: BPP]); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    do_reset();
    a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(a, NB);
    do_latch();
    // Second frame ends with its last s_clk edge landing on the latch edge.
    send_bits(b >> 1, NB - 1);
    @(negedge clk);
    s_sda = b[0]; s_clk = 1'b1; latch = 1'b1;
    @(negedge clk);
    s_clk = 1'b0;
    tick(1);
    latch = 1'b0;
    tick(1);
    model_bit(b[0]);
    model_latch();
    checks++; if (err_len !== 1'b0) $display("FAIL b2b_err_len got %b want 0", err_len); else passes++;
    do_select(8'h08);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); rd_addr = {3'd3, 3'(r)};
      @(negedge clk);
      checks++; if (rd_data !== b[BPP*r +: BPP] || rd_data !== m_col[3][BPP*r +: BPP])
        $display("FAIL b2b_row%0d got %h want %h", r, rd_data, b[BPP*r +: BPP]); else passes++;
    end
  endtask

  task automatic test_loopback();
    logic [BPP-1:0] pix [8][8];
    logic [BPP-1:0] p [8];
    int fd0;
    bit ok;
    do_reset();
    fd0 = fd_seen;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) pix[c][r] = BPP'($urandom);
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) p[r] = pix[c][r];
      send_column(p, c);
    end
    ok = 1;
    for (int a = 0; a < 64; a++) begin
      @(negedge clk); rd_addr = 6'(a);
      @(negedge clk);
      if (rd_data !== pix[a/8][a%8]) begin
        $display("FAIL loopback addr %o got %h want %h", a, rd_data, pix[a/8][a%8]);
        ok = 0;
      end
    end
    checks++; if (ok) passes++;
    checks++; if (fd_seen - fd0 !== 1) $display("FAIL loopback_frame_done got %0d want 1", fd_seen - fd0); else passes++;
    checks++; if ({err_len, err_chan} !== {m_err_len, m_err_chan})
      $display("FAIL loopback_errs got %b want %b", {err_len, err_chan}, {m_err_len, m_err_chan}); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_full_frame();
    test_short_frame();
    test_bad_channel();
    test_reset_mid_frame();
    test_back_to_back();
    test_loopback();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dm163_rx_monitor.md
DM163_RX_MONITOR -- requirements
Module: dm163_rx_monitor

Interface
REQ-001 SHALL have parameter PIXELS_PER_COL, default 8: pixels per column, one per serial frame.
REQ-002 SHALL have parameter BITS_PER_PIXEL, default 24: bits per pixel; N_BITS = PIXELS_PER_COL*BITS_PER_PIXEL (192).
REQ-003 SHALL have port clk, input, 1: system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port s_sda, input, 1: serial data, synchronous to clk.
REQ-006 SHALL have port s_clk, input, 1: serial clock level, synchronous to clk.
REQ-007 SHALL have port latch, input, 1: DM163 latch strobe level.
REQ-008 SHALL have port channel, input, 8: one-hot column select.
REQ-009 SHALL have port rd_addr, input, 6: {col[2:0], row[2:0]} pixel read address.
REQ-010 SHALL have port rd_data, output, BITS_PER_PIXEL: captured pixel value.
REQ-011 SHALL have port col_valid, output, 8: bit c set once column c has been captured since reset or last frame_done.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse when column 7 is captured.
REQ-013 SHALL have ports err_len, err_chan, outputs, 1 each: sticky error flags.

Function
REQ-014 SHALL register s_clk, latch and channel each cycle; a rising edge is current=1 and previous=0.
REQ-015 SHALL on each s_clk rising edge shift s_sda into shift register bit 0, shifting existing bits toward MSB; first bit of a frame ends at bit N_BITS-1.
REQ-016 SHALL count shifted bits in a saturating counter (max 255), cleared on latch rising edge.
REQ-017 SHALL on latch rising edge copy shift register to hold register; err_len set if count != N_BITS; hold still updates.
REQ-018 SHALL run FSM IDLE -> HELD on latch rising edge; HELD -> IDLE on channel rising from 0 to nonzero; another latch edge in HELD overwrites hold, stays HELD.
REQ-019 SHALL on HELD->IDLE with channel one-hot bit c write hold into column c, set col_valid[c]; column index = channel bit position.
REQ-020 SHALL if channel nonzero but not one-hot on that transition discard write, set err_chan, return IDLE.
REQ-021 SHALL treat channel changes in IDLE as no-ops.
REQ-022 SHALL pack row r of a column at hold bits [24r+23:24r].
REQ-023 SHALL register rd_data one cycle after rd_addr (latency 1); a write to the read column shows new data on the following read cycle.
REQ-024 SHALL pulse frame_done the cycle after column 7 write and clear col_valid to 0 in that same cycle.
REQ-025 SHALL accept s_clk edge coincident with latch edge: shift first, then the shifted value is held.
REQ-026 SHALL keep err_len, err_chan sticky until reset.

Reset
REQ-027 SHALL on rst_n low clear shift, hold, column memory, counter, edge registers, col_valid, rd_data, frame_done, errors to 0; FSM to IDLE.
REQ-028 SHALL on reset mid-frame discard partial bits; next frame counted from zero.

Structure
REQ-029 SHALL place PIXELS_PER_COL, BITS_PER_PIXEL, N_BITS and FSM state encodings in shared package dm163_pkg.
REQ-030 SHALL use one sub-module, edge_detect (rising-edge detector, registered previous value), instantiated for s_clk, latch, channel-nonzero.
REQ-031 SHALL implement column memory as 8 x N_BITS registers, no RAM macro.

Verification
REQ-032 SHALL cover: 192 bits of 0xFF0000 per row, latch, channel=8'h01 -> rd_addr 6'o00..07 returns 24'hFF0000, col_valid=8'h01, no errors.
REQ-033 SHALL cover: columns 0..7 with distinct patterns 24'h0000C0+c -> frame_done single pulse after column 7, col_valid returns 8'h00, all 64 reads match.
REQ-034 SHALL cover: 191 bits then latch -> err_len=1, data still written on next channel select.
REQ-035 SHALL cover: after latch, channel=8'h03 -> err_chan=1, col_valid unchanged, FSM IDLE.
REQ-036 SHALL cover: rst_n low after 100 bits, then full frame -> correct capture, err_len=0.
REQ-037 SHALL cover: loopback with pixel_column_mux driving inputs, 64 pixels written, send_frame -> all rd_data match written values.
